// File: rtl/alu_pkg.sv
// Shared constants for the ALU accumulator sequencer: state encoding and datapath widths.
`timescale 1ns/1ps
package alu_pkg;
    localparam int ALU_W        = 8;
    localparam int SEL_W        = 3;
    localparam int SETTLE_CNT_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/alu_settle_cnt.sv
// Loadable down-counter that times the ALU settle window; stops at zero and flags terminal count.
`timescale 1ns/1ps
module alu_settle_cnt
    import alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [SETTLE_CNT_W-1:0] load_val,
    input  logic                    en,
    output logic                    zero
);
    logic [SETTLE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/alu_acc_sequencer.sv
// Accumulator front/back end around a combinational 8-bit ALU: accepts a command, holds the
// ALU inputs for SETTLE_CYCLES, captures result and carry, then presents them on a response port.
//
// state | meaning
// IDLE  | ready for a command; cmd_ready high
// EXEC  | ALU inputs held stable while the settle counter runs down
// RESP  | result presented on res_*; waits for res_ready
`timescale 1ns/1ps
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [SEL_W-1:0] cmd_op,
    input  logic [ALU_W-1:0] cmd_operand,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ALU_W-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero
);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [ALU_W-1:0] acc;
    logic [ALU_W-1:0] b_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             carry;
    logic             cmd_accept;
    logic             cnt_zero;

    assign cmd_ready  = (state == IDLE);
    assign res_valid  = (state == RESP);
    assign cmd_accept = cmd_valid && cmd_ready;

    // Counter value 0 on the accept edge means a single EXEC cycle.
    alu_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cmd_accept && !cmd_load),
        .load_val (SETTLE_LOAD),
        .en       (state == EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            b_reg   <= '0;
            sel_reg <= '0;
            carry   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sel_reg <= cmd_op;
                        b_reg   <= cmd_operand;
                        if (cmd_load) begin
                            acc   <= cmd_operand;
                            carry <= 1'b0;
                            state <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_zero) begin
                        acc   <= alu_out;
                        carry <= alu_carry;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_a     = acc;
    assign alu_b     = b_reg;
    assign alu_sel   = sel_reg;
    assign res_data  = acc;
    assign res_carry = carry;
    assign res_zero  = (acc == '0);
endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
Sequential front/back end for the team's combinational 8-bit ALU. It accepts commands over a valid/ready handshake and drives the ALU's A, B and select inputs from an internal 8-bit accumulator and the command operand. After a fixed settle time it captures the ALU result and carry back into the accumulator, then presents the result on a valid/ready response port. It sits directly around the ALU: upstream of its inputs and downstream of its outputs.

Parameters:
SETTLE_CYCLES, 1, number of cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_load  input  1  1 = load cmd_operand directly into the accumulator and bypass the ALU.
cmd_op  input  3  ALU select for this command; passed through to the ALU without decoding.
cmd_operand  input  8  B operand, or the load value when cmd_load=1.
alu_a  output  8  to ALU A input; equals the accumulator.
alu_b  output  8  to ALU B input; registered operand.
alu_sel  output  3  to ALU select input; registered op.
alu_out  input  8  ALU result.
alu_carry  input  1  ALU carry out.
res_valid  output  1  response present.
res_ready  input  1  consumer accepts the response.
res_data  output  8  accumulator value after the command.
res_carry  output  1  captured carry; 0 for loads.
res_zero  output  1  1 when res_data == 8'h00.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; accumulator, alu_b, alu_sel, carry flag and settle counter all 0. Outputs at reset: cmd_ready=1, res_valid=0, res_data=0, res_carry=0, res_zero=1.
- FSM states: IDLE, EXEC, RESP.
- cmd_ready = (state==IDLE). This is combinational from state only; it never depends on cmd_valid.
- IDLE: when cmd_valid & cmd_ready at an edge, cmd_op is registered into alu_sel and cmd_operand into alu_b.
  - cmd_load=1: accumulator <= cmd_operand and carry <= 0 on that same edge; next state RESP.
  - cmd_load=0: counter <= SETTLE_CYCLES-1; next state EXEC.
- EXEC: alu_a/alu_b/alu_sel are held constant. The counter decrements each cycle.
  - When the counter is 0 at an edge: accumulator <= alu_out, carry <= alu_carry, state <= RESP.
  - alu_out is sampled exactly once per command; values while settling are ignored.
- RESP: res_valid=1 with res_data=accumulator, res_carry=carry, res_zero=(accumulator==0).
  - These outputs are held stable while res_ready=0, with no limit on backpressure.
  - On res_valid & res_ready at an edge: state <= IDLE.
- res_valid = (state==RESP).
- res_data/res_carry/res_zero are also driven outside RESP: they always reflect the current accumulator and carry.
- Latency, ALU command: accept edge T, capture edge T+SETTLE_CYCLES, res_valid high from T+SETTLE_CYCLES onward. Throughput is at most one command per SETTLE_CYCLES+2 cycles.
- Latency, load command: res_valid high in the cycle following the accept edge.
- No command overlap: cmd_valid during EXEC/RESP is ignored, and the upstream must hold it until accepted.
- The accumulator width is fixed at 8. Results are whatever the ALU returns; the block performs no arithmetic itself.
- Reset mid-EXEC or mid-RESP: immediate return to reset values; the pending response is discarded.

Decomposition:
- Shared package/header alu_pkg holds:
  - state encoding localparams (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - ALU_W=8 and SEL_W=3;
  - SETTLE_CNT_W=4.
- The natural sub-module is alu_settle_cnt: a loadable down-counter with a zero flag.
- FSM and datapath registers stay in the top module.

Test Plan:
- Bench ALU stub (combinational): sel 3'b000 -> {carry,out} = alu_a + alu_b; sel 3'b101 -> out = alu_a ^ alu_b, carry 0.
- Reset: hold rst_n low 3 cycles, then release -> cmd_ready=1, res_valid=0, res_data=8'h00, res_zero=1.
- Load then add: load 8'hF0, then op 000 with operand 8'h20, SETTLE_CYCLES=1 -> second response res_data=8'h10, res_carry=1, res_zero=0; res_valid rises exactly 1 cycle after the accept edge.
- XOR to zero and settle: load 8'h5A, op 101 with operand 8'h5A, SETTLE_CYCLES=3 -> res_data=8'h00, res_zero=1, res_carry=0. alu_b and alu_sel are constant for all 3 EXEC cycles, and the stub output is glitched in cycle 1 to confirm only the final cycle is sampled.
- Backpressure: hold res_ready=0 for 5 cycles during RESP while cmd_valid=1 -> res_* stable, cmd_ready=0, no second command accepted; the command is accepted in the first IDLE cycle after res_ready.
- Reset mid-operation: assert rst_n low during EXEC of an add on accumulator 8'h33 -> accumulator=8'h00, res_valid never rises for that command, cmd_ready=1 once reset is released.
